// File: rtl/stopwatch_uart_ctrl.sv
// stopwatch_uart_ctrl
// Decodes single-byte ASCII commands from the UART receiver into stopwatch
// go/clr/up controls. It also streams an 8-byte "M:SS.T\r\n" report of the
// BCD digits into the UART TX FIFO. A report starts on request or on a
// periodic auto tick.
module stopwatch_uart_ctrl #(
  parameter int unsigned REPORT_DVSR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       go,
  output logic       clr,
  output logic       up,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [31:0] LP_LAST = (REPORT_DVSR == 0) ? 32'd0 : 32'(REPORT_DVSR - 1);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [3:0]  r_d3, r_d2, r_d1, r_d0;
  logic [7:0]  r_last;
  logic [31:0] r_cnt;
  logic        r_go, r_clr, r_up;

  logic [7:0]  w_cmd;
  logic        w_is_g, w_is_p, w_is_c, w_is_u, w_is_d, w_is_r;
  logic        w_auto_tick, w_req, w_busy, w_wr;
  logic [7:0]  w_byte;

  // Case-folding by setting bit 5 maps exactly 'X' and 'x' onto the same code
  assign w_cmd  = rx_data | 8'h20;
  assign w_is_g = rx_done_tick && (w_cmd == 8'h67);
  assign w_is_p = rx_done_tick && (w_cmd == 8'h70);
  assign w_is_c = rx_done_tick && (w_cmd == 8'h63);
  assign w_is_u = rx_done_tick && (w_cmd == 8'h75);
  assign w_is_d = rx_done_tick && (w_cmd == 8'h64);
  assign w_is_r = rx_done_tick && (w_cmd == 8'h72);

  assign w_auto_tick = (REPORT_DVSR != 0) && r_go && (r_cnt == LP_LAST);
  assign w_req       = w_is_r || w_auto_tick;

  // Stopwatch control registers; clear is a single-cycle pulse that also stops the watch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_go  <= 1'b0;
      r_clr <= 1'b0;
      r_up  <= 1'b1;
    end else begin
      r_clr <= w_is_c;
      if (w_is_g) r_go <= 1'b1;
      if (w_is_p || w_is_c) r_go <= 1'b0;
      if (w_is_u) r_up <= 1'b1;
      if (w_is_d) r_up <= 1'b0;
    end
  end

  // Auto-report period counter: runs only while go is set, wraps at the period end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_is_c) begin
      r_cnt <= '0;
    end else if (r_go) begin
      if (r_cnt == LP_LAST) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 32'd1;
    end
  end

  // Report FSM: snapshot the digits on request, then emit one byte per non-full cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_d3    <= '0;
      r_d2    <= '0;
      r_d1    <= '0;
      r_d0    <= '0;
      r_last  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_d3    <= d3;
            r_d2    <= d2;
            r_d1    <= d1;
            r_d0    <= d0;
            r_idx   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_full) begin
            r_last <= w_byte;
            r_idx  <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Report byte selected by the current index
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0: w_byte = {4'h3, r_d3};
      3'd1: w_byte = 8'h3A;
      3'd2: w_byte = {4'h3, r_d2};
      3'd3: w_byte = {4'h3, r_d1};
      3'd4: w_byte = 8'h2E;
      3'd5: w_byte = {4'h3, r_d0};
      3'd6: w_byte = 8'h0D;
      3'd7: w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  // The write strobe depends on tx_full in the same cycle so that a byte can go out
  // on the first SEND cycle. w_data shows the last written byte whenever no write occurs.
  assign w_busy  = (r_state == S_SEND);
  assign w_wr    = w_busy && !tx_full;
  assign wr_uart = w_wr;
  assign w_data  = w_wr ? w_byte : r_last;
  assign busy    = w_busy;
  assign go      = r_go;
  assign clr     = r_clr;
  assign up      = r_up;

endmodule

// File: tb/tb_stopwatch_uart_ctrl.sv
// Self-checking bench for stopwatch_uart_ctrl. Expected report bytes are queued
// when a report is requested and popped by a monitor whenever wr_uart fires.
module tb_stopwatch_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [3:0] d3, d2, d1, d0;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       go, clr, up, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [7:0] exp_q[$];

  stopwatch_uart_ctrl #(.REPORT_DVSR(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .d3           (d3),
    .d2           (d2),
    .d1           (d1),
    .d0           (d0),
    .tx_full      (tx_full),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .go           (go),
    .clr          (clr),
    .up           (up),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write must match the oldest expected byte
  always @(negedge clk) begin
    if (!reset && wr_uart) begin
      wr_count++;
      n_checks++;
      if (tx_full) begin
        n_fail++;
        $display("FAIL wr_while_full: wr_uart=1 tx_full=1 at %0t", $time);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got 0x%02h, expected no write at %0t", w_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (w_data !== e) begin
          n_fail++;
          $display("FAIL report_byte: got 0x%02h, expected 0x%02h at %0t", w_data, e, $time);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic push_report(input logic [3:0] a3, input logic [3:0] a2,
                             input logic [3:0] a1, input logic [3:0] a0);
    exp_q.push_back(8'h30 + {4'h0, a3});
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h30 + {4'h0, a2});
    exp_q.push_back(8'h30 + {4'h0, a1});
    exp_q.push_back(8'h2E);
    exp_q.push_back(8'h30 + {4'h0, a0});
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b, expected 0 within bound", name, busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_queue: %0d bytes outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; tx_full = 1'b0;
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({go, clr, up, wr_uart, busy, w_data} !== {5'b00100, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values: go,clr,up,wr,busy,w_data=%b%b%b%b%b,%02h expected 00100,00",
               go, clr, up, wr_uart, busy, w_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_go_up;
    send_byte(8'h67);
    @(negedge clk);
    n_checks++;
    if (go !== 1'b1 || clr !== 1'b0) begin
      n_fail++;
      $display("FAIL go_cmd: go=%b clr=%b, expected go=1 clr=0", go, clr);
    end
    send_byte(8'h64);
    @(negedge clk);
    n_checks++;
    if (up !== 1'b0 || clr !== 1'b0) begin
      n_fail++;
      $display("FAIL down_cmd: up=%b clr=%b, expected up=0 clr=0", up, clr);
    end
    send_byte(8'h55);
    @(negedge clk);
    n_checks++;
    if (up !== 1'b1) begin
      n_fail++;
      $display("FAIL up_cmd: up=%b, expected 1", up);
    end
    send_byte(8'h43);
    @(negedge clk);
    n_checks++;
    if (clr !== 1'b1 || go !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_cmd: clr=%b go=%b, expected clr=1 go=0", clr, go);
    end
    @(negedge clk);
    n_checks++;
    if (clr !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_pulse_width: clr=%b, expected 0", clr);
    end
  endtask

  task automatic test_report;
    int start;
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    push_report(4'd1, 4'd2, 4'd3, 4'd4);
    start = wr_count;
    send_byte(8'h72);
    d3 = 4'd9; d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL report_consecutive: cycle %0d wr_uart=%b busy=%b, expected 1,1", i, wr_uart, busy);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_uart !== 1'b0) begin
      n_fail++;
      $display("FAIL report_busy_fall: busy=%b wr_uart=%b, expected 0,0", busy, wr_uart);
    end
    #1;
    n_checks++;
    if (wr_count - start != 8) begin
      n_fail++;
      $display("FAIL report_count: %0d writes, expected 8", wr_count - start);
    end
  endtask

  task automatic test_backpressure;
    int start;
    d3 = 4'd5; d2 = 4'd6; d1 = 4'd7; d0 = 4'd8;
    push_report(4'd5, 4'd6, 4'd7, 4'd8);
    start = wr_count;
    send_byte(8'h52);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (wr_uart !== 1'b0 || busy !== 1'b1 || w_data !== 8'h36) begin
        n_fail++;
        $display("FAIL full_hold: wr_uart=%b busy=%b w_data=%02h, expected 0,1,36", wr_uart, busy, w_data);
      end
    end
    @(posedge clk); #1;
    tx_full = 1'b0;
    wait_idle("backpressure");
    n_checks++;
    if (wr_count - start != 8) begin
      n_fail++;
      $display("FAIL backpressure_count: %0d writes, expected 8", wr_count - start);
    end
  endtask

  task automatic test_back_to_back;
    int start;
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    send_byte(8'h47);
    push_report(4'd1, 4'd2, 4'd3, 4'd4);
    start = wr_count;
    send_byte(8'h72);
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    send_byte(8'h52);
    send_byte(8'h63);
    @(negedge clk);
    n_checks++;
    if (clr !== 1'b1 || go !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_clr: clr=%b go=%b busy=%b, expected 1,0,1", clr, go, busy);
    end
    @(negedge clk);
    n_checks++;
    if (clr !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_clr_once: clr=%b, expected 0", clr);
    end
    wait_idle("drop");
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (wr_count - start != 8) begin
      n_fail++;
      $display("FAIL drop_count: %0d writes, expected 8", wr_count - start);
    end
  endtask

  task automatic test_auto_report;
    int start;
    logic s_go, s_up;
    d3 = 4'd0; d2 = 4'd4; d1 = 4'd2; d0 = 4'd7;
    push_report(4'd0, 4'd4, 4'd2, 4'd7);
    push_report(4'd0, 4'd4, 4'd2, 4'd7);
    start = wr_count;
    send_byte(8'h67);
    repeat (45) @(posedge clk);
    send_byte(8'h70);
    repeat (40) @(negedge clk);
    #1;
    n_checks++;
    if (wr_count - start != 16 || go !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_count: %0d writes go=%b, expected 16 writes go=0", wr_count - start, go);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL auto_queue: %0d bytes outstanding, expected 0", exp_q.size());
    end
    s_go = go; s_up = up;
    start = wr_count;
    send_byte(8'h78);
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (go !== s_go || up !== s_up || clr !== 1'b0 || busy !== 1'b0 || wr_count != start) begin
      n_fail++;
      $display("FAIL unknown_byte: go=%b up=%b clr=%b busy=%b writes=%0d, expected %b,%b,0,0,0",
               go, up, clr, busy, wr_count - start, s_go, s_up);
    end
  endtask

  task automatic test_reset_mid_report;
    int start;
    send_byte(8'h63);
    send_byte(8'h64);
    send_byte(8'h67);
    d3 = 4'd3; d2 = 4'd1; d1 = 4'd4; d0 = 4'd1;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h31);
    send_byte(8'h72);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({wr_uart, busy, go, up, clr, w_data} !== {5'b00010, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_abort: wr,busy,go,up,clr,w_data=%b%b%b%b%b,%02h expected 00010,00",
               wr_uart, busy, go, up, clr, w_data);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_partial: %0d bytes outstanding, expected 0", exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    push_report(4'd3, 4'd1, 4'd4, 4'd1);
    start = wr_count;
    send_byte(8'h72);
    wait_idle("after_reset");
    n_checks++;
    if (wr_count - start != 8) begin
      n_fail++;
      $display("FAIL after_reset_count: %0d writes, expected 8", wr_count - start);
    end
  endtask

  initial begin
    test_reset();
    test_go_up();
    test_report();
    test_backpressure();
    test_back_to_back();
    test_auto_report();
    test_reset_mid_report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
